// File: rtl/hazard_ctrl.sv
// Hazard controller for the five-stage pipeline.
// Produces the ALU operand-forwarding selects, the pipeline stall and flush
// controls, a sticky memory-timeout error and two performance counters.
// The forwarding, stall and flush outputs are purely combinational so they
// take effect in the same cycle the hazard is seen.
module hazard_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [4:0]  rs1_addr_D,
  input  logic [4:0]  rs2_addr_D,
  input  logic [4:0]  rs1_addr_E,
  input  logic [4:0]  rs2_addr_E,
  input  logic [4:0]  rd_addr_E,
  input  logic [4:0]  rd_addr_M,
  input  logic [4:0]  rd_addr_W,
  input  logic        reg_wr_en_M,
  input  logic        reg_wr_en_W,
  input  logic        is_load_E,
  input  logic        mispredict_E,
  input  logic        mem_req_M,
  input  logic        mem_ack_M,
  output logic [1:0]  forward_A_E,
  output logic [1:0]  forward_B_E,
  output logic        stall_F,
  output logic        stall_D,
  output logic        stall_E,
  output logic        stall_M,
  output logic        flush_D,
  output logic        flush_E,
  output logic        mem_err,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
);

  // The memory-wait tracker: RUN while memory is idle or answering, WAIT
  // while a request is outstanding, ERR once it has waited too long.
  typedef enum logic [1:0] {
    RUN  = 2'd0,
    WAIT = 2'd1,
    ERR  = 2'd2
  } state_t;

  localparam logic [7:0] TIMEOUT_CNT = 8'(MEM_TIMEOUT);

  state_t     state;
  state_t     state_nxt;
  logic [7:0] wait_cnt;
  logic [7:0] wait_cnt_nxt;

  logic       load_use;
  logic       mem_wait;

  // Select the source for one ALU operand: the younger M stage wins over W,
  // and register x0 is never forwarded because it always reads as zero.
  function automatic logic [1:0] fwd_sel(input logic [4:0] rs);
    logic [1:0] sel;
    sel = 2'b00;
    if (reg_wr_en_M && (rd_addr_M != 5'd0) && (rd_addr_M == rs)) begin
      sel = 2'b10;
    end else if (reg_wr_en_W && (rd_addr_W != 5'd0) && (rd_addr_W == rs)) begin
      sel = 2'b01;
    end
    return sel;
  endfunction

  // Operand forwarding for both Execute-stage sources.
  always_comb begin
    forward_A_E = fwd_sel(rs1_addr_E);
    forward_B_E = fwd_sel(rs2_addr_E);
  end

  // Hazard conditions: a load in E feeding an instruction in D, and a data
  // memory request that has not completed this cycle.
  always_comb begin
    load_use = is_load_E && (rd_addr_E != 5'd0) &&
               ((rd_addr_E == rs1_addr_D) || (rd_addr_E == rs2_addr_D));
    mem_wait = mem_req_M && !mem_ack_M;
  end

  // State register for the memory-wait tracker; reset returns to RUN at once.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state    <= RUN;
      wait_cnt <= 8'd0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
    end
  end

  // Next-state logic: count consecutive wait cycles and give up into ERR
  // once the count has reached the timeout while memory is still busy.
  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    case (state)
      RUN: begin
        if (mem_wait) begin
          state_nxt    = WAIT;
          wait_cnt_nxt = 8'd1;
        end else begin
          wait_cnt_nxt = 8'd0;
        end
      end
      WAIT: begin
        if (!mem_wait) begin
          state_nxt    = RUN;
          wait_cnt_nxt = 8'd0;
        end else if (wait_cnt == TIMEOUT_CNT) begin
          state_nxt = ERR;
        end else begin
          wait_cnt_nxt = wait_cnt + 8'd1;
        end
      end
      ERR: begin
        state_nxt = ERR;
      end
      default: begin
        state_nxt    = RUN;
        wait_cnt_nxt = 8'd0;
      end
    endcase
  end

  assign mem_err = (state == ERR);

  // Stall/flush priority. A memory wait (or a dead memory) freezes the
  // whole pipe, which also holds a pending mispredict in E until the wait
  // clears; a mispredict then squashes D and E, and a load-use hazard holds
  // F/D for one cycle while a bubble goes into E.
  always_comb begin
    stall_F = 1'b0;
    stall_D = 1'b0;
    stall_E = 1'b0;
    stall_M = 1'b0;
    flush_D = 1'b0;
    flush_E = 1'b0;
    if ((state == ERR) || mem_wait) begin
      stall_F = 1'b1;
      stall_D = 1'b1;
      stall_E = 1'b1;
      stall_M = 1'b1;
    end else if (mispredict_E) begin
      flush_D = 1'b1;
      flush_E = 1'b1;
    end else if (load_use) begin
      stall_F = 1'b1;
      stall_D = 1'b1;
      flush_E = 1'b1;
    end
  end

  // Performance counters: cycles with the front end stalled and cycles with
  // Decode flushed, each saturating rather than wrapping.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_cnt <= 32'd0;
      flush_cnt <= 32'd0;
    end else begin
      if (stall_F && (stall_cnt != 32'hFFFF_FFFF)) begin
        stall_cnt <= stall_cnt + 32'd1;
      end
      if (flush_D && (flush_cnt != 32'hFFFF_FFFF)) begin
        flush_cnt <= flush_cnt + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios followed by
// randomized traffic, all compared against a behavioural model.
module tb_hazard_ctrl;

  localparam int TIMEOUT = 4;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic [4:0]  rs1_addr_D, rs2_addr_D, rs1_addr_E, rs2_addr_E, rd_addr_E;
  logic [4:0]  rd_addr_M, rd_addr_W;
  logic        reg_wr_en_M, reg_wr_en_W, is_load_E, mispredict_E;
  logic        mem_req_M, mem_ack_M;
  logic [1:0]  forward_A_E, forward_B_E;
  logic        stall_F, stall_D, stall_E, stall_M, flush_D, flush_E, mem_err;
  logic [31:0] stall_cnt, flush_cnt;

  int checkCount = 0;
  int failCount  = 0;

  // Behavioural model state: consecutive busy-memory cycles, sticky error,
  // and the two counters.
  bit              modelErr;
  int              consecWait;
  longint unsigned modelStallCnt;
  longint unsigned modelFlushCnt;

  hazard_ctrl #(.MEM_TIMEOUT(TIMEOUT)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .rs1_addr_D(rs1_addr_D), .rs2_addr_D(rs2_addr_D),
    .rs1_addr_E(rs1_addr_E), .rs2_addr_E(rs2_addr_E), .rd_addr_E(rd_addr_E),
    .rd_addr_M(rd_addr_M), .rd_addr_W(rd_addr_W),
    .reg_wr_en_M(reg_wr_en_M), .reg_wr_en_W(reg_wr_en_W),
    .is_load_E(is_load_E), .mispredict_E(mispredict_E),
    .mem_req_M(mem_req_M), .mem_ack_M(mem_ack_M),
    .forward_A_E(forward_A_E), .forward_B_E(forward_B_E),
    .stall_F(stall_F), .stall_D(stall_D), .stall_E(stall_E), .stall_M(stall_M),
    .flush_D(flush_D), .flush_E(flush_E), .mem_err(mem_err),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  // Free-running 10 ns clock.
  always #5 clk_i = ~clk_i;

  // Safety net so the run always ends.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  function automatic logic [1:0] expFwd(input logic [4:0] rs);
    if (rs == 5'd0) return 2'b00;
    if (reg_wr_en_M && rd_addr_M == rs) return 2'b10;
    if (reg_wr_en_W && rd_addr_W == rs) return 2'b01;
    return 2'b00;
  endfunction

  // Expected {stall_F, stall_D, stall_E, stall_M, flush_D, flush_E}.
  function automatic logic [5:0] expCtl();
    bit memBusy;
    bit loadUse;
    memBusy = mem_req_M && !mem_ack_M;
    loadUse = is_load_E && (rd_addr_E != 0) &&
              ((rd_addr_E == rs1_addr_D) || (rd_addr_E == rs2_addr_D));
    if (modelErr || memBusy) return 6'b111100;
    if (mispredict_E)        return 6'b000011;
    if (loadUse)             return 6'b110001;
    return 6'b000000;
  endfunction

  task automatic modelReset();
    modelErr      = 0;
    consecWait    = 0;
    modelStallCnt = 0;
    modelFlushCnt = 0;
  endtask

  task automatic modelTick(input logic [5:0] ctl);
    if (ctl[5] && modelStallCnt < 64'hFFFF_FFFF) modelStallCnt++;
    if (ctl[1] && modelFlushCnt < 64'hFFFF_FFFF) modelFlushCnt++;
    if (!modelErr) begin
      consecWait = (mem_req_M && !mem_ack_M) ? consecWait + 1 : 0;
      if (consecWait > TIMEOUT) modelErr = 1;
    end
  endtask

  task automatic checkComb();
    checkOutput("fwdA", 32'(forward_A_E), 32'(expFwd(rs1_addr_E)));
    checkOutput("fwdB", 32'(forward_B_E), 32'(expFwd(rs2_addr_E)));
    checkOutput("ctl", 32'({stall_F, stall_D, stall_E, stall_M, flush_D, flush_E}),
                32'(expCtl()));
  endtask

  task automatic checkRegs();
    checkOutput("memErr", 32'(mem_err), 32'(modelErr));
    checkOutput("stallCnt", stall_cnt, 32'(modelStallCnt));
    checkOutput("flushCnt", flush_cnt, 32'(modelFlushCnt));
  endtask

  // One clock cycle with the currently driven inputs.
  task automatic applyStimulus();
    logic [5:0] ctl;
    #1;
    checkComb();
    ctl = expCtl();
    @(posedge clk_i);
    modelTick(ctl);
    #1;
    checkRegs();
  endtask

  // Reset pulse with the current inputs left in place, checked while asserted.
  task automatic doReset();
    rst_ni = 1'b0;
    modelReset();
    #1;
    checkRegs();
    checkComb();
    @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  task automatic idleInputs();
    rs1_addr_D = 0; rs2_addr_D = 0; rs1_addr_E = 0; rs2_addr_E = 0;
    rd_addr_E = 0; rd_addr_M = 0; rd_addr_W = 0;
    reg_wr_en_M = 0; reg_wr_en_W = 0; is_load_E = 0; mispredict_E = 0;
    mem_req_M = 0; mem_ack_M = 0;
  endtask

  initial begin
    int burst;
    idleInputs();
    rst_ni = 1'b1;
    modelReset();
    #2;
    doReset();

    // Forwarding priority and x0 handling.
    rs2_addr_E = 5; rd_addr_M = 5; rd_addr_W = 5; reg_wr_en_M = 1; reg_wr_en_W = 1;
    #1 checkOutput("fwdB_M", 32'(forward_B_E), 32'h2);
    applyStimulus();
    rd_addr_M = 0;
    #1 checkOutput("fwdB_W", 32'(forward_B_E), 32'h1);
    applyStimulus();
    reg_wr_en_M = 0; reg_wr_en_W = 0;
    #1 checkOutput("fwdB_none", 32'(forward_B_E), 32'h0);
    applyStimulus();
    idleInputs();

    // Load-use bubble for one cycle, none when the load targets x0.
    is_load_E = 1; rd_addr_E = 7; rs1_addr_D = 7;
    #1 checkOutput("loadUse", 32'({stall_F, stall_D, flush_E}), 32'h7);
    applyStimulus();
    is_load_E = 0; rs1_addr_D = 0;
    #1 checkOutput("loadUseDone", 32'(stall_F), 32'h0);
    applyStimulus();
    is_load_E = 1; rd_addr_E = 0; rs1_addr_D = 0;
    #1 checkOutput("loadUseX0", 32'(stall_F), 32'h0);
    applyStimulus();
    idleInputs();

    // Mispredict beats load-use.
    doReset();
    mispredict_E = 1; is_load_E = 1; rd_addr_E = 3; rs2_addr_D = 3;
    #1 checkOutput("mispLoad", 32'({flush_D, flush_E, stall_F}), 32'h6);
    applyStimulus();
    checkOutput("mispFlushCnt", flush_cnt, 32'd1);
    idleInputs();

    // Memory wait of three cycles, then ack.
    doReset();
    mem_req_M = 1;
    repeat (3) applyStimulus();
    mem_ack_M = 1;
    #1 checkOutput("ackNoStall", 32'(stall_M), 32'h0);
    applyStimulus();
    checkOutput("waitStallCnt", stall_cnt, 32'd3);
    idleInputs();

    // Timeout into ERR on the fifth edge, then recovery by reset.
    doReset();
    mem_req_M = 1;
    repeat (4) applyStimulus();
    checkOutput("errNotYet", 32'(mem_err), 32'h0);
    applyStimulus();
    checkOutput("errSet", 32'(mem_err), 32'h1);
    mem_req_M = 0;
    applyStimulus();
    checkOutput("errStuckStall", 32'({stall_F, stall_D, stall_E, stall_M}), 32'hF);
    doReset();
    checkOutput("errCleared", 32'(mem_err), 32'h0);
    checkOutput("cntCleared", stall_cnt | flush_cnt, 32'h0);
    checkOutput("stallAfterRst", 32'(stall_F), 32'h0);
    applyStimulus();

    // Reset mid-wait: stalls follow mem_wait only during reset.
    mem_req_M = 1;
    repeat (2) applyStimulus();
    rst_ni = 1'b0;
    modelReset();
    #1 checkOutput("rstMidWaitStall", 32'(stall_F), 32'h1);
    checkOutput("rstMidWaitCnt", stall_cnt, 32'h0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    mem_req_M = 0;
    applyStimulus();
    idleInputs();

    // Mispredict held across a memory wait, flush once it clears.
    doReset();
    mem_req_M = 1; mispredict_E = 1;
    repeat (2) begin
      #1 checkOutput("mispHeldStall", 32'({stall_F, flush_D, flush_E}), 32'h4);
      applyStimulus();
    end
    mem_ack_M = 1;
    #1 checkOutput("mispAfterWait", 32'({stall_F, flush_D, flush_E}), 32'h3);
    applyStimulus();
    idleInputs();

    // Randomized traffic against the model.
    burst = 0;
    for (int i = 0; i < 600; i++) begin
      rs1_addr_D  = 5'($urandom_range(0, 3));
      rs2_addr_D  = 5'($urandom_range(0, 3));
      rs1_addr_E  = 5'($urandom_range(0, 3));
      rs2_addr_E  = 5'($urandom_range(0, 3));
      rd_addr_E   = 5'($urandom_range(0, 3));
      rd_addr_M   = 5'($urandom_range(0, 3));
      rd_addr_W   = 5'($urandom_range(0, 3));
      reg_wr_en_M = 1'($urandom_range(0, 1));
      reg_wr_en_W = 1'($urandom_range(0, 1));
      is_load_E   = ($urandom_range(0, 2) == 0);
      mispredict_E = ($urandom_range(0, 5) == 0);
      if (burst == 0 && $urandom_range(0, 60) == 0) burst = $urandom_range(3, 8);
      if (burst > 0) begin
        mem_req_M = 1; mem_ack_M = 0; burst--;
      end else begin
        mem_req_M = ($urandom_range(0, 2) == 0);
        mem_ack_M = 1'($urandom_range(0, 1));
      end
      if ($urandom_range(0, 50) == 0) doReset();
      else applyStimulus();
    end

    $display("== %0d vectors applied, %0d miscompares ==", checkCount, failCount);
    $finish;
  end

endmodule
